// File: rtl/henad_pkg.sv
// Shared Henad definitions used by the instruction-memory loader.
//   HENAD_ADDR_W / HENAD_DATA_W : instruction memory address and word widths.
//   ldr_state_t                 : loader FSM state encoding.
package henad_pkg;

    localparam int HENAD_ADDR_W = 12;
    localparam int HENAD_DATA_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CHK,
        DONE,
        ERR
    } ldr_state_t;

endpackage

// File: rtl/henad_imem_loader_if.sv
// Valid/ready word stream feeding the loader.
//   s_valid : source has a word
//   s_data  : stream word
//   s_ready : sink accepts the word this cycle
// master = stream source, slave = loader.
interface henad_imem_loader_if
    import henad_pkg::*;
#(
    parameter int DATA_W = HENAD_DATA_W
);

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/henad_imem_loader.sv
// Boot-time program loader for the Henad core.
// Receives header N, N data words and a checksum word over a valid/ready
// stream, writes the data words to instruction memory addresses 0..N-1 and
// releases the core from reset only after a good checksum.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : single-cycle load request (honoured in IDLE/DONE/ERR)
//   stream          : word stream (slave side)
//   mem_we/addr/wdata : registered instruction memory write port
//   core_rst        : reset to the core, low only in DONE
//   busy/done/err   : load in progress / good checksum / bad checksum
module henad_imem_loader
    import henad_pkg::*;
#(
    parameter int ADDR_W = HENAD_ADDR_W,
    parameter int DATA_W = HENAD_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    henad_imem_loader_if.slave   stream,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 core_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    // The data word count is compared against N and used as the address,
    // so both widths must agree.
    if (ADDR_W != DATA_W) begin : g_width_check
        $error("henad_imem_loader: ADDR_W must equal DATA_W");
    end

    ldr_state_t        state_reg, state_next;
    logic [DATA_W-1:0] n_reg, n_next;
    logic [DATA_W-1:0] sum_reg, sum_next;
    logic [ADDR_W-1:0] count_reg, count_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;

    logic              in_stream;
    logic              hs;
    logic [DATA_W-1:0] chk_sum;
    logic              last_data;

    // Ready is a pure state decode: no path from s_valid back to s_ready.
    assign in_stream      = (state_reg == HDR) || (state_reg == DATA) || (state_reg == CHK);
    assign stream.s_ready = in_stream;
    assign hs             = stream.s_valid && in_stream;
    assign chk_sum        = sum_reg + stream.s_data;
    assign last_data      = (count_reg == ADDR_W'(n_reg - DATA_W'(1)));

    assign busy      = in_stream;
    assign core_rst  = (state_reg != DONE);
    assign done      = (state_reg == DONE);
    assign err       = (state_reg == ERR);
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            sum_reg   <= '0;
            count_reg <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            sum_reg   <= sum_next;
            count_reg <= count_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        sum_next   = sum_reg;
        count_next = count_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;

        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (hs) begin
                    n_next     = stream.s_data;
                    sum_next   = stream.s_data;
                    count_next = '0;
                    state_next = (stream.s_data == '0) ? CHK : DATA;
                end
            end
            DATA: begin
                if (hs) begin
                    we_next    = 1'b1;
                    addr_next  = count_reg;
                    wdata_next = stream.s_data;
                    sum_next   = chk_sum;
                    count_next = count_reg + ADDR_W'(1);
                    if (last_data) begin
                        state_next = CHK;
                    end
                end
            end
            CHK: begin
                if (hs) begin
                    state_next = (chk_sum == '0) ? DONE : ERR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_henad_imem_loader.sv
// Directed self-checking bench for henad_imem_loader: reset state, good and
// bad loads, empty program, backpressure with an ignored start, mid-load reset.
module tb_henad_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [11:0] mem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    henad_imem_loader_if #(.DATA_W(12)) s_if ();

    henad_imem_loader #(.ADDR_W(12), .DATA_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stream    (s_if.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;

    // Write monitor: logs each committed write with its cycle number.
    int          cyc = 0;
    int          wr_addr_q[$];
    int          wr_data_q[$];
    int          wr_cyc_q[$];
    logic [11:0] exp_d [8];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_we) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(int'(mem_wdata));
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one word after 'gaps' idle cycles; valid stays high afterwards
    // so consecutive calls with gaps=0 stream back-to-back.
    task automatic send(input logic [11:0] w, input int gaps);
        int n;
        repeat (gaps) begin
            s_if.s_valid = 1'b0;
            tick();
        end
        s_if.s_valid = 1'b1;
        s_if.s_data  = w;
        n = 0;
        while (!s_if.s_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_if.s_ready) check("ready_timeout", 32'd0, 32'd1);
        else               tick();
    endtask

    task automatic idle();
        s_if.s_valid = 1'b0;
        s_if.s_data  = 12'h000;
    endtask

    task automatic check_wr(input string tag, input int n, input bit consec);
        check({tag, "_wr_cnt"}, wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], int'(exp_d[i]));
            if (consec && i > 0)
                check($sformatf("%s_gap%0d", tag, i), wr_cyc_q[i] - wr_cyc_q[i-1], 1);
        end
    endtask

    task automatic good_stream();
        send(12'h003, 0);
        send(12'h001, 0);
        send(12'h002, 0);
        send(12'h003, 0);
        send(12'hFF7, 0);
        idle();
    endtask

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = 12'h000;

        // Reset state
        repeat (3) tick();
        check("rst_s_ready", s_if.s_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        repeat (20) tick();
        check("idle_no_we", wr_addr_q.size(), 0);
        check("idle_core_rst", core_rst, 1);
        check("idle_s_ready", s_if.s_ready, 0);

        // Good load of three words
        clear_log();
        do_start();
        check("hdr_s_ready", s_if.s_ready, 1);
        check("hdr_busy", busy, 1);
        send(12'h003, 0);
        send(12'h001, 0);
        send(12'h002, 0);
        send(12'h003, 0);
        check("chk_core_rst", core_rst, 1);
        check("chk_done", done, 0);
        send(12'hFF7, 0);
        idle();
        check("good_done", done, 1);
        check("good_core_rst", core_rst, 0);
        check("good_err", err, 0);
        check("good_busy", busy, 0);
        check("good_s_ready", s_if.s_ready, 0);
        exp_d[0] = 12'h001; exp_d[1] = 12'h002; exp_d[2] = 12'h003;
        check_wr("good", 3, 1'b1);

        // Bad checksum, then recovery with a good stream
        do_start();
        check("restart_done", done, 0);
        check("restart_core_rst", core_rst, 1);
        send(12'h003, 0);
        send(12'h001, 0);
        send(12'h002, 0);
        send(12'h003, 0);
        send(12'h000, 0);
        idle();
        check("bad_err", err, 1);
        check("bad_done", done, 0);
        check("bad_core_rst", core_rst, 1);
        do_start();
        check("retry_err", err, 0);
        good_stream();
        check("retry_done", done, 1);

        // Empty program
        do_start();
        clear_log();
        send(12'h000, 0);
        send(12'h000, 0);
        idle();
        tick();
        check("empty_done", done, 1);
        check("empty_no_we", wr_addr_q.size(), 0);

        // Backpressure with a start pulse during DATA (must be ignored)
        do_start();
        clear_log();
        send(12'h004, 1);
        send(12'h010, $urandom_range(0, 2));
        send(12'h020, $urandom_range(0, 2));
        s_if.s_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bp_start_ignored_busy", busy, 1);
        send(12'h030, $urandom_range(0, 2));
        send(12'h040, $urandom_range(0, 2));
        send(12'hF5C, $urandom_range(0, 2));
        idle();
        check("bp_done", done, 1);
        exp_d[0] = 12'h010; exp_d[1] = 12'h020; exp_d[2] = 12'h030; exp_d[3] = 12'h040;
        check_wr("bp", 4, 1'b0);

        // Mid-load reset after the second data word of N=5
        do_start();
        clear_log();
        send(12'h005, 0);
        send(12'h100, 0);
        send(12'h200, 0);
        rst = 1'b1;
        idle();
        #1;
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_s_ready", s_if.s_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_core_rst", core_rst, 1);
        tick();
        tick();
        check("mid_rst_pre_writes", wr_addr_q.size(), 1);
        rst = 1'b0;
        clear_log();
        repeat (5) tick();
        check("post_rst_no_we", wr_addr_q.size(), 0);
        check("post_rst_idle_ready", s_if.s_ready, 0);
        do_start();
        send(12'h005, 0);
        send(12'h100, 0);
        send(12'h200, 0);
        send(12'h300, 0);
        send(12'h400, 0);
        send(12'h500, 0);
        send(12'h0FB, 0);
        idle();
        check("reload_done", done, 1);
        exp_d[0] = 12'h100; exp_d[1] = 12'h200; exp_d[2] = 12'h300;
        exp_d[3] = 12'h400; exp_d[4] = 12'h500;
        check_wr("reload", 5, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/henad_imem_loader.md
# henad_imem_loader

Boot-time program loader for the Henad core. It receives a length-prefixed, checksummed stream of 12-bit instruction words over a valid/ready interface and writes them into the instruction memory that the core's IA/IF stages fetch from. It holds the core in reset until the whole program has been written and the checksum has passed.

## Interface
Parameters:
- `ADDR_W`, 12, instruction memory address width; must equal `DATA_W`.
- `DATA_W`, 12, instruction word width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to begin a load.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  DATA_W  stream word.
- `s_ready`  out  1  loader accepts a word this cycle.
- `mem_we`  out  1  instruction memory write enable.
- `mem_addr`  out  ADDR_W  instruction memory write address.
- `mem_wdata`  out  DATA_W  instruction memory write data.
- `core_rst`  out  1  active-high reset to the Henad core.
- `busy`  out  1  a load is in progress.
- `done`  out  1  load completed with a good checksum.
- `err`  out  1  load completed with a checksum mismatch.

## Operation
- Stream format: header word N (0..4095 data words), then N data words, then one checksum word C.
- A load passes when (N + Σdata + C) mod 2^DATA_W == 0.
- A handshake occurs on a cycle with `s_valid && s_ready`.
- FSM states: IDLE, HDR, DATA, CHK, DONE, ERR.
  - IDLE: `core_rst`=1. `start` moves to HDR.
  - HDR: on handshake, latch N, set sum=N and count=0. If N==0, go to CHK; otherwise go to DATA.
  - DATA: on handshake, write `s_data` to address count, add it to sum (mod 2^12), and increment count. The handshake with count==N-1 moves to CHK.
  - CHK: on handshake, go to DONE if (sum + `s_data`) mod 4096 == 0; otherwise go to ERR.
  - DONE: `core_rst`=0, `done`=1.
  - ERR: `core_rst`=1, `err`=1.
  - In DONE or ERR, `start` returns to HDR. This clears `done`/`err` and re-asserts `core_rst`.
- `start` is ignored in HDR, DATA and CHK.
- Output decode by state:
  - `s_ready`=1 only in HDR, DATA and CHK.
  - `busy`=1 only in HDR, DATA and CHK.
  - `core_rst`=1 in every state except DONE.
- Handshakes in HDR and CHK never cause a memory write.
- Address 4095 is never written, because at most 4095 data words are loaded (addresses 0..4094).
- Memory contents outside 0..N-1 are untouched.
- Reset values: state IDLE, `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_rst`=1, `busy`=0, `done`=0, `err`=0. Internal count and sum are 0.
- Reset in the middle of a load returns everything to the reset values immediately. Words already written stay in memory. A new load needs a fresh `start`.

## Timing
- Throughput: one word per cycle when `s_valid` is held high. There are no bubbles between the header, data and checksum words.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. The write appears on the cycle after the data handshake, and `mem_we` is a one-cycle pulse per word.
- `s_ready` is a pure decode of the state register, so it has no combinational path from `s_valid`.
- State changes take effect on the cycle after the handshake. `core_rst` falls, and `done` rises, on the cycle after the checksum handshake.
- The last data write (issued the cycle after the last data handshake) always completes no later than the checksum handshake. The core therefore never leaves reset before memory is fully written.
- `start` in IDLE, DONE or ERR: HDR is entered the next cycle, and `s_ready` is 1 that cycle.

## Structure
- Shared package `henad_pkg` holds:
  - the loader state enum `ldr_state_t`;
  - the constants `HENAD_ADDR_W`=12 and `HENAD_DATA_W`=12.
- Single module. The checksum accumulator and counter are inline; no sub-module is warranted.
- The top level drives the core's reset from `core_rst` ORed with the system `rst`.
- The instruction memory gets a write port fed by `mem_we`/`mem_addr`/`mem_wdata`.

## Test plan
- Reset check: apply `rst` → all outputs at their reset values, `core_rst`=1; no `mem_we` for 20 cycles without `start`.
- Good load: `start`, then stream 0x003, 0x001, 0x002, 0x003, 0xFF7 back-to-back → expect:
  - writes (0,0x001), (1,0x002), (2,0x003) on consecutive cycles;
  - `done`=1 and `core_rst`=0 one cycle after the 0xFF7 handshake.
- Bad checksum: same stream ending in 0x000 → `err`=1, `done`=0, `core_rst`=1. A later `start` followed by a good stream → `done`=1.
- Empty program: `start`, then 0x000, 0x000 → no `mem_we`, `done`=1.
- Backpressure and ignored start: N=4 with random `s_valid` gaps, plus `start` pulsed during DATA → the same four writes in order, a single load, `done`=1.
- Mid-load reset: assert `rst` after the 2nd data word of N=5 → reset values, and no `mem_we` after reset. A new `start` and full stream → `done`=1 with all 5 words written.
